// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package rf_arb_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // Source of the write currently held in the output register.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MAC
  } wb_src_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for outstanding MAC results, with a sticky
// double-issue error and a three-port RAW hazard compare for ID.
module reg_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int NREG = rf_arb_pkg::NREG,
  parameter int AW   = rf_arb_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            r1_en,
  input  logic [AW-1:0]   r1_addr,
  input  logic            r2_en,
  input  logic [AW-1:0]   r2_addr,
  input  logic            r3_en,
  input  logic [AW-1:0]   r3_addr,
  output logic            hazard,
  output logic [NREG-1:0] busy_vec,
  output logic            sb_err
);

  logic [NREG-1:0] busy_q, busy_nxt;
  logic            set_live, err_nxt;

  assign set_live = set_en && (set_addr != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a
    // path that skips an assignment infers a latch.
    busy_nxt = busy_q;
    err_nxt  = sb_err;
    if (clr_en)
      busy_nxt[clr_addr] = 1'b0;
    // Set is applied after clear so a same-register collision leaves it busy.
    if (set_live) begin
      busy_nxt[set_addr] = 1'b1;
      if (busy_q[set_addr] && !(clr_en && clr_addr == set_addr))
        err_nxt = 1'b1;
    end
  end

  // NOTE: the busy bits are plain flops, not a RAM, so they are cleared by
  // reset like any other state; an unreset scoreboard would stall ID forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only, so every
      // flop samples pre-edge values regardless of statement order.
      busy_q <= busy_nxt;
      sb_err <= err_nxt;
    end
  end

  assign busy_vec = busy_q;

  assign hazard = (r1_en && r1_addr != '0 && busy_q[r1_addr])
               || (r2_en && r2_addr != '0 && busy_q[r2_addr])
               || (r3_en && r3_addr != '0 && busy_q[r3_addr]);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB and the MAC
// unit, with an aging counter so a blocked MAC result cannot starve.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREG     = rf_arb_pkg::NREG,
  parameter int AW       = rf_arb_pkg::AW,
  parameter int DW       = rf_arb_pkg::DW,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  input  logic [AW-1:0]   pipe_addr,
  input  logic [DW-1:0]   pipe_data,
  output logic            pipe_ready,
  input  logic            mac_valid,
  input  logic [AW-1:0]   mac_addr,
  input  logic [DW-1:0]   mac_data,
  output logic            mac_ready,
  input  logic            mac_issue,
  input  logic [AW-1:0]   mac_issue_addr,
  input  logic            id_r1_en,
  input  logic [AW-1:0]   id_r1_addr,
  input  logic            id_r2_en,
  input  logic [AW-1:0]   id_r2_addr,
  input  logic            id_r3_en,
  input  logic [AW-1:0]   id_r3_addr,
  output logic            hazard,
  output logic [NREG-1:0] busy_vec,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic            sb_err
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       mac_pri;
  wb_src_t    src_q;

  // The MAC side takes priority once it has aged to MAX_WAIT.
  assign mac_pri    = (wait_cnt == MAX_WAIT_C);
  assign mac_ready  = !reset && mac_valid && (!pipe_valid || mac_pri);
  assign pipe_ready = !reset && pipe_valid && !(mac_valid && mac_pri);

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!mac_valid || mac_ready)
      wait_cnt_nxt = '0;
    else if (wait_cnt < MAX_WAIT_C)
      wait_cnt_nxt = wait_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      src_q    <= SRC_NONE;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      rf_we    <= 1'b0;
      src_q    <= SRC_NONE;
      // Writes to r0 complete the handshake but never reach the file.
      if (mac_ready && mac_addr != '0) begin
        rf_we    <= 1'b1;
        rf_waddr <= mac_addr;
        rf_wdata <= mac_data;
        src_q    <= SRC_MAC;
      end else if (pipe_ready && pipe_addr != '0) begin
        rf_we    <= 1'b1;
        rf_waddr <= pipe_addr;
        rf_wdata <= pipe_data;
        src_q    <= SRC_PIPE;
      end
    end
  end

  reg_scoreboard #(
    .NREG(NREG),
    .AW  (AW)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (mac_issue),
    .set_addr(mac_issue_addr),
    .clr_en  (rf_we && src_q == SRC_MAC),
    .clr_addr(rf_waddr),
    .r1_en   (id_r1_en),
    .r1_addr (id_r1_addr),
    .r2_en   (id_r2_en),
    .r2_addr (id_r2_addr),
    .r3_en   (id_r3_en),
    .r3_addr (id_r3_addr),
    .hazard  (hazard),
    .busy_vec(busy_vec),
    .sb_err  (sb_err)
  );

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle MAC unit. It also keeps a per-register scoreboard of outstanding MAC results, so ID can stall on RAW hazards against any of its three read ports. It sits between WB/MAC and the register file write inputs, with a combinational hazard output back to ID.

## Interface
- NREG, 32, number of architectural registers (register 0 hardwired zero)
- AW, 5, register address width
- DW, 32, data width
- MAX_WAIT, 4, cycles a blocked MAC result may wait before it takes priority over the pipeline (1..15)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- pipe_valid  in  1  WB stage has a result
- pipe_addr  in  AW  WB destination
- pipe_data  in  DW  WB result
- pipe_ready  out  1  WB result accepted this cycle
- mac_valid  in  1  MAC unit has a result
- mac_addr  in  AW  MAC destination
- mac_data  in  DW  MAC result
- mac_ready  out  1  MAC result accepted this cycle
- mac_issue  in  1  ID dispatched a MAC op this cycle
- mac_issue_addr  in  AW  destination of the dispatched MAC
- id_r1_en, id_r2_en, id_r3_en  in  1 each  ID read-port enables
- id_r1_addr, id_r2_addr, id_r3_addr  in  AW each  ID read addresses
- hazard  out  1  ID must stall (combinational)
- busy_vec  out  NREG  scoreboard state
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  AW  register file write address (registered)
- rf_wdata  out  DW  register file write data (registered)
- sb_err  out  1  sticky: a MAC was issued to an already-busy register

## Operation
- Grant is combinational and evaluated each cycle:
  - only one side valid: that side is ready.
  - both valid: pipe wins by default; MAC wins when wait_cnt == MAX_WAIT.
  - pipe_ready and mac_ready are never both 1.
  - both ready signals are 0 while reset is high.
- wait_cnt (4 bits):
  - +1 on every cycle with mac_valid && !mac_ready, saturating at MAX_WAIT.
  - cleared on a MAC grant, or when mac_valid is low.
- Accepted write to address 0: handshake completes, but rf_we stays 0 and the scoreboard is unchanged.
- Scoreboard, busy[NREG-1:0]:
  - set: mac_issue && mac_issue_addr != 0 sets busy[mac_issue_addr].
  - clear: busy[rf_waddr] clears at the clock edge that ends a cycle with rf_we = 1 and source = MAC.
  - same-register set and clear in one cycle: set wins.
  - mac_issue to a register already busy (and not being cleared that cycle) sets sb_err, which holds until reset.
  - pipe writes never touch busy bits.
- hazard = OR over k=1..3 of (id_rk_en && id_rk_addr != 0 && busy[id_rk_addr]).
  - The scoreboard is the only hazard source; there is no bypass from rf_wdata.

## Timing
- Handshake accepted in cycle N (valid && ready):
  - rf_we/rf_waddr/rf_wdata show the write in cycle N+1.
  - the register file captures it at the end of N+1.
  - the busy clear for a MAC write happens on that same edge.
- rf_we is 1 for exactly one cycle per accepted non-zero write; it is 0 on cycles with no grant.
- A MAC blocked by continuous pipe traffic is granted by cycle N+MAX_WAIT after it first asserts valid.
- The valid source must hold addr and data stable until ready.
- Reset (asynchronous, any time):
  - rf_we, rf_waddr, rf_wdata, busy_vec, sb_err and wait_cnt go to 0.
  - hazard goes to 0.
  - a write registered but not yet committed is dropped.

## Structure
- Package rf_arb_pkg:
  - AW, DW and NREG defaults.
  - enum wb_src_t {SRC_NONE, SRC_PIPE, SRC_MAC}, registered alongside rf_we to qualify busy clears.
- Sub-module reg_scoreboard: holds busy bits, set/clear/priority, sb_err and the three-port hazard compare.
- Grant logic, wait counter and output register stay in the top module.

## Test plan
- Pipe only: pipe_valid with addr 5, data 0xDEAD_BEEF at cycle N. Required: pipe_ready=1 at N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at N+1; rf_we=0 at N+2.
- Contention: pipe_valid held high, mac_valid with addr 7, MAX_WAIT=4. Required: mac_ready=0 for 4 cycles, then mac_ready=1 with pipe_ready=0; wait_cnt returns to 0.
- Scoreboard: mac_issue addr 9, then ID reads r2=9 with enable. Required: hazard=1 until the cycle after the MAC write's rf_we cycle. With r2_en=0 or address 0, hazard=0.
- Set/clear collision: MAC write to 9 committing on the same edge as a new mac_issue to 9. Required: busy[9]=1 afterwards and sb_err=0. A second issue to 9 while busy is still set gives sb_err=1, and it stays 1.
- Zero address: pipe write to r0 and mac_issue to r0. Required: pipe_ready=1, rf_we=0, busy_vec unchanged.
- Async reset mid-write: assert reset between grant and the rf_we cycle. Required: rf_we, busy_vec, sb_err and hazard all 0 immediately; no write appears after reset is released.
